// File: rtl/id_scoreboard_pkg.sv
// id_scoreboard_pkg: shared scoreboard sizes, decode latency constants and aluop-to-latency mapping
package id_scoreboard_pkg;
  localparam int SB_NREGS  = 32;
  localparam int SB_REG_AW = 5;
  localparam int SB_CNT_W  = 3;
  localparam int SB_STAT_W = 32;
  localparam logic [SB_CNT_W-1:0] LAT_ALU  = 3'd0;
  localparam logic [SB_CNT_W-1:0] LAT_LOAD = 3'd1;
  localparam logic [SB_CNT_W-1:0] LAT_MUL  = 3'd3;
  localparam logic [SB_CNT_W-1:0] LAT_DIV  = 3'd7;
  typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_MUL, OP_DIV} aluop_e;
  function automatic logic [SB_CNT_W-1:0] lat_of(aluop_e op);
    return op == OP_LOAD ? LAT_LOAD : op == OP_MUL ? LAT_MUL : op == OP_DIV ? LAT_DIV : LAT_ALU;
  endfunction
endpackage

// File: rtl/id_scoreboard_if.sv
// id_scoreboard_if: decode<->scoreboard bundle (issue, operand reads, writeback in; stalls, busy_vec, stall_cycles out)
interface id_scoreboard_if import id_scoreboard_pkg::*; #(
  parameter int NREGS  = SB_NREGS,
  parameter int REG_AW = SB_REG_AW,
  parameter int CNT_W  = SB_CNT_W,
  parameter int STAT_W = SB_STAT_W
);
  logic              issue_valid;
  logic              issue_we;
  logic [REG_AW-1:0] issue_rd;
  logic [CNT_W-1:0]  issue_lat;
  logic              flush;
  logic              rs1_re;
  logic [REG_AW-1:0] rs1_addr;
  logic              rs2_re;
  logic [REG_AW-1:0] rs2_addr;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic              stallreq;
  logic              stall_raw1;
  logic              stall_raw2;
  logic              stall_waw;
  logic [NREGS-1:0]  busy_vec;
  logic [STAT_W-1:0] stall_cycles;
  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat, flush,
    input  rs1_re, rs1_addr, rs2_re, rs2_addr, wb_valid, wb_addr,
    output stallreq, stall_raw1, stall_raw2, stall_waw, busy_vec, stall_cycles
  );
  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat, flush,
    output rs1_re, rs1_addr, rs2_re, rs2_addr, wb_valid, wb_addr,
    input  stallreq, stall_raw1, stall_raw2, stall_waw, busy_vec, stall_cycles
  );
endinterface

// File: rtl/id_scoreboard_sb_entry.sv
// id_scoreboard_sb_entry: one register's busy/countdown pair (clk, rst, issue+lat load, wb clear; busy, cnt out), issue beats writeback
module id_scoreboard_sb_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [CNT_W-1:0] lat,
  input  logic             wb,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);
  logic             busy_d, busy_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    busy_d = rst ? 1'b0 : issue ? 1'b1 : wb ? 1'b0 : busy_q;
    cnt_d  = rst ? '0 : issue ? lat : wb ? '0 : cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    busy_q <= busy_d;
    cnt_q  <= cnt_d;
  end
  assign busy = busy_q;
  assign cnt  = cnt_q;
endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write scoreboard (clk, rst, bus slave) raising RAW/WAW stalls and counting stall cycles
module id_scoreboard import id_scoreboard_pkg::*; #(
  parameter int NREGS  = SB_NREGS,
  parameter int REG_AW = SB_REG_AW,
  parameter int CNT_W  = SB_CNT_W,
  parameter int STAT_W = SB_STAT_W
) (
  input logic clk,
  input logic rst,
  id_scoreboard_if.slave bus
);
  logic [NREGS-1:0]  busy;
  logic [CNT_W-1:0]  cnt [NREGS];
  logic              raw1, raw2, waw, stall, fire;
  logic [STAT_W-1:0] stall_cycles_d, stall_cycles_q;
  assign busy[0] = 1'b0;
  assign cnt[0]  = '0;
  for (genvar r = 1; r < NREGS; r++) begin : g_ent
    id_scoreboard_sb_entry #(.CNT_W(CNT_W)) u_ent (
      .clk   (clk),
      .rst   (rst),
      .issue (fire && bus.issue_rd == REG_AW'(r)),
      .lat   (bus.issue_lat),
      .wb    (bus.wb_valid && bus.wb_addr == REG_AW'(r)),
      .busy  (busy[r]),
      .cnt   (cnt[r])
    );
  end
  always_comb begin
    raw1  = !rst && bus.rs1_re && bus.rs1_addr != '0 && busy[bus.rs1_addr] && cnt[bus.rs1_addr] != '0;
    raw2  = !rst && bus.rs2_re && bus.rs2_addr != '0 && busy[bus.rs2_addr] && cnt[bus.rs2_addr] != '0;
    waw   = !rst && bus.issue_valid && bus.issue_we && bus.issue_rd != '0 && busy[bus.issue_rd] &&
            cnt[bus.issue_rd] > bus.issue_lat;
    stall = !rst && bus.issue_valid && !bus.flush && (raw1 || raw2 || waw);
    fire  = bus.issue_valid && bus.issue_we && bus.issue_rd != '0 && !bus.flush && !stall;
    stall_cycles_d = rst ? '0 : stall && !(&stall_cycles_q) ? stall_cycles_q + STAT_W'(1) : stall_cycles_q;
  end
  always_ff @(posedge clk) stall_cycles_q <= stall_cycles_d;
  assign bus.stall_raw1   = raw1;
  assign bus.stall_raw2   = raw2;
  assign bus.stall_waw    = waw;
  assign bus.stallreq     = stall;
  assign bus.busy_vec     = busy;
  assign bus.stall_cycles = stall_cycles_q;
  a_wb_after_ready: assert property (@(posedge clk) disable iff (rst)
    bus.wb_valid && bus.wb_addr != '0 |-> cnt[bus.wb_addr] == '0)
    else $error("id_scoreboard: writeback to x%0d while latency outstanding", bus.wb_addr);
endmodule
